// File: rtl/dual_port_ram_p.sv
// Parametrised true dual-port synchronous RAM with per-port read-valid strobes,
// selectable read-during-write mode, write-collision arbitration and a clear sequencer.
module dual_port_ram_p #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned RDW_MODE   = 0,
   parameter int unsigned OUT_REG    = 0,
   parameter int unsigned CLR_ON_RST = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              busy,
   input  logic              en_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] din_a,
   output logic [DATA_W-1:0] dout_a,
   output logic              vld_a,
   input  logic              en_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] din_b,
   output logic [DATA_W-1:0] dout_b,
   output logic              vld_b,
   output logic              collision
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   cnt;
   logic                start_pend;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic [1:0]                   en_v;
   logic [1:0]                   we_v;
   logic [1:0][ADDR_W-1:0]       addr_v;
   logic [1:0][DATA_W-1:0]       din_v;
   logic [1:0][DATA_W-1:0]       dout_v;
   logic [1:0]                   vld_v;
   logic                         wr_a;
   logic                         wr_b;
   logic                         hit;

   // Clear sequencer: start_pend arms the automatic post-reset clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         start_pend <= (CLR_ON_RST != 0);
      end else begin
         case (state)
            IDLE: begin
               if (start_pend || clr) begin
                  state      <= CLEAR;
                  cnt        <= '0;
                  start_pend <= 1'b0;
               end
            end
            CLEAR: begin
               if (cnt == CNT_MAX) state <= IDLE;
               else                cnt   <= cnt + ADDR_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == CLEAR);

   assign en_v   = {en_b & ~busy, en_a & ~busy};
   assign we_v   = {we_b, we_a};
   assign addr_v = {addr_b, addr_a};
   assign din_v  = {din_b, din_a};

   assign wr_a = en_v[0] & we_a;
   assign wr_b = en_v[1] & we_b;
   assign hit  = wr_a & wr_b & (addr_a == addr_b);

   // Array write: clear has priority; on a same-address double write port A wins
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[cnt] <= '0;
      end else begin
         if (wr_a)        mem[addr_a] <= din_a;
         if (wr_b && !hit) mem[addr_b] <= din_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) collision <= 1'b0;
      else        collision <= hit;
   end

   for (genvar g = 0; g < 2; g++) begin : g_port
      logic [DATA_W-1:0] d1;
      logic              v1;
      logic [DATA_W-1:0] dout_r;
      logic              vld_r;

      // First read stage; reads sample pre-write contents so cross-port reads see old data
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d1 <= '0;
            v1 <= 1'b0;
         end else begin
            v1 <= 1'b0;
            if (en_v[g]) begin
               if (!we_v[g]) begin
                  d1 <= mem[addr_v[g]];
                  v1 <= 1'b1;
               end else if (RDW_MODE == 1) begin
                  d1 <= din_v[g];
                  v1 <= 1'b1;
               end else if (RDW_MODE == 2) begin
                  d1 <= mem[addr_v[g]];
                  v1 <= 1'b1;
               end
            end
         end
      end

      if (OUT_REG != 0) begin : g_oreg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_r <= '0;
               vld_r  <= 1'b0;
            end else begin
               vld_r <= v1;
               if (v1) dout_r <= d1;
            end
         end
      end else begin : g_noreg
         assign dout_r = d1;
         assign vld_r  = v1;
      end

      assign dout_v[g] = dout_r;
      assign vld_v[g]  = vld_r;
   end

   assign dout_a = dout_v[0];
   assign vld_a  = vld_v[0];
   assign dout_b = dout_v[1];
   assign vld_b  = vld_v[1];

endmodule

// File: tb/tb_dual_port_ram_p.sv
// Directed bench for dual_port_ram_p: four instances share stimulus to cover
// RDW_MODE 0/1/2 (OUT_REG=0) and OUT_REG=1 (RDW_MODE=0).
module tb_dual_port_ram_p;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       en_a;
   logic       we_a;
   logic [5:0] addr_a;
   logic [7:0] din_a;
   logic       en_b;
   logic       we_b;
   logic [5:0] addr_b;
   logic [7:0] din_b;

   logic       busy      [4];
   logic [7:0] dout_a    [4];
   logic       vld_a     [4];
   logic [7:0] dout_b    [4];
   logic       vld_b     [4];
   logic       collision [4];

   int vectors     = 0;
   int miscompares = 0;

   // Instance 0: mode 0, 1: write-first, 2: read-first, 3: mode 0 with output register
   for (genvar g = 0; g < 4; g++) begin : g_dut
      dual_port_ram_p #(
         .DATA_W    (8),
         .ADDR_W    (6),
         .RDW_MODE  ((g == 1) ? 1 : (g == 2) ? 2 : 0),
         .OUT_REG   ((g == 3) ? 1 : 0),
         .CLR_ON_RST(1)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (clr),
         .busy     (busy[g]),
         .en_a     (en_a),
         .we_a     (we_a),
         .addr_a   (addr_a),
         .din_a    (din_a),
         .dout_a   (dout_a[g]),
         .vld_a    (vld_a[g]),
         .en_b     (en_b),
         .we_b     (we_b),
         .addr_b   (addr_b),
         .din_b    (din_b),
         .dout_b   (dout_b[g]),
         .vld_b    (vld_b[g]),
         .collision(collision[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Counts busy cycles of a clear run; optionally attempts accesses near its end
   task automatic run_clear(input bit inject);
      int n = 0;
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (busy[0]) begin
            n++;
            if (inject && n == 62) begin
               en_a = 1'b1; we_a = 1'b1; addr_a = 6'd2; din_a = 8'h77;
               en_b = 1'b1; we_b = 1'b0; addr_b = 6'd0;
            end
            if (inject && n == 63) begin
               chk1("busy_vld_a", vld_a[0], 1'b0);
               chk1("busy_vld_b", vld_b[0], 1'b0);
               en_a = 1'b0; we_a = 1'b0; en_b = 1'b0;
            end
         end else if (n > 0) begin
            done = 1'b1;
         end
      end
      chk32("busy_cycles", n, 64);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0;
      en_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
      en_b = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0;

      repeat (3) @(negedge clk);
      chk1("rst_busy", busy[0], 1'b0);
      chk1("rst_vld_a", vld_a[0], 1'b0);
      chk8("rst_dout_a", dout_a[0], 8'h00);
      chk1("rst_collision", collision[0], 1'b0);

      rst_n = 1'b1;
      run_clear(1'b0);

      // Post-clear reads at latency 1
      en_a = 1'b1; we_a = 1'b0; addr_a = 6'd0;
      @(negedge clk);
      chk8("clr_rd0", dout_a[0], 8'h00); chk1("clr_rd0_vld", vld_a[0], 1'b1);
      addr_a = 6'd31;
      @(negedge clk);
      chk8("clr_rd31", dout_a[0], 8'h00); chk1("clr_rd31_vld", vld_a[0], 1'b1);
      addr_a = 6'd63;
      @(negedge clk);
      chk8("clr_rd63", dout_a[0], 8'h00); chk1("clr_rd63_vld", vld_a[0], 1'b1);
      en_a = 1'b0;
      @(negedge clk);
      chk1("idle_vld_a", vld_a[0], 1'b0);

      // A writes 0x5A, B reads it back; latency 1 and latency 2
      en_a = 1'b1; we_a = 1'b1; addr_a = 6'd10; din_a = 8'h5A;
      @(negedge clk);
      en_a = 1'b0; we_a = 1'b0; en_b = 1'b1; we_b = 1'b0; addr_b = 6'd10;
      @(negedge clk);
      chk8("lat1_dout_b", dout_b[0], 8'h5A); chk1("lat1_vld_b", vld_b[0], 1'b1);
      chk1("lat2_early_vld_b", vld_b[3], 1'b0);
      en_b = 1'b0;
      @(negedge clk);
      chk8("lat2_dout_b", dout_b[3], 8'h5A); chk1("lat2_vld_b", vld_b[3], 1'b1);
      chk1("lat1_vld_b_drop", vld_b[0], 1'b0);

      // Cross-port read during write returns old data
      en_a = 1'b1; we_a = 1'b1; addr_a = 6'd7; din_a = 8'h11;
      @(negedge clk);
      din_a = 8'h22; en_b = 1'b1; we_b = 1'b0; addr_b = 6'd7;
      @(negedge clk);
      chk8("xport_old", dout_b[0], 8'h11);
      en_a = 1'b0; we_a = 1'b0;
      @(negedge clk);
      chk8("xport_new", dout_b[0], 8'h22);
      en_b = 1'b0;

      // Same-port read-during-write across modes
      en_a = 1'b1; we_a = 1'b0; addr_a = 6'd7;
      @(negedge clk);
      chk8("pre_rdw_rd7", dout_a[0], 8'h22);
      we_a = 1'b1; addr_a = 6'd3; din_a = 8'h11;
      @(negedge clk);
      din_a = 8'h33;
      @(negedge clk);
      chk8("rdw0_dout", dout_a[0], 8'h22); chk1("rdw0_vld", vld_a[0], 1'b0);
      chk8("rdw1_dout", dout_a[1], 8'h33); chk1("rdw1_vld", vld_a[1], 1'b1);
      chk8("rdw2_dout", dout_a[2], 8'h11); chk1("rdw2_vld", vld_a[2], 1'b1);
      en_a = 1'b0; we_a = 1'b0;
      @(negedge clk);
      chk1("en0_vld_a", vld_a[1], 1'b0);
      en_a = 1'b1; addr_a = 6'd3;
      @(negedge clk);
      chk8("rd3", dout_a[0], 8'h33);
      en_a = 1'b0;

      // Write-write collision on the same address, then on different addresses
      en_a = 1'b1; we_a = 1'b1; addr_a = 6'd20; din_a = 8'hAA;
      en_b = 1'b1; we_b = 1'b1; addr_b = 6'd20; din_b = 8'hBB;
      @(negedge clk);
      chk1("coll_set", collision[0], 1'b1);
      en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
      @(negedge clk);
      chk1("coll_pulse_end", collision[0], 1'b0);
      en_a = 1'b1; addr_a = 6'd20;
      @(negedge clk);
      chk8("coll_a_wins", dout_a[0], 8'hAA);
      we_a = 1'b1; din_a = 8'hCC;
      en_b = 1'b1; we_b = 1'b1; addr_b = 6'd21; din_b = 8'hDD;
      @(negedge clk);
      chk1("coll_diff_addr", collision[0], 1'b0);
      we_a = 1'b0; we_b = 1'b0;
      @(negedge clk);
      chk8("diff_rd20", dout_a[0], 8'hCC);
      chk8("diff_rd21", dout_b[0], 8'hDD);
      en_a = 1'b0; en_b = 1'b0;

      // Seed non-zero data, start a clear, abort it with reset, let it restart
      en_a = 1'b1; we_a = 1'b1; addr_a = 6'd0;  din_a = 8'hFF;
      en_b = 1'b1; we_b = 1'b1; addr_b = 6'd63; din_b = 8'hFF;
      @(negedge clk);
      en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk1("clr_busy", busy[0], 1'b1);
      repeat (29) @(negedge clk);
      chk1("mid_clear_busy", busy[0], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk1("abort_busy", busy[0], 1'b0);
      chk8("abort_dout_a", dout_a[0], 8'h00);
      @(negedge clk);
      chk1("abort_busy_hold", busy[0], 1'b0);
      rst_n = 1'b1;
      run_clear(1'b1);

      en_a = 1'b1; we_a = 1'b0; addr_a = 6'd0;
      en_b = 1'b1; we_b = 1'b0; addr_b = 6'd63;
      @(negedge clk);
      chk8("reclr_rd0", dout_a[0], 8'h00);
      chk8("reclr_rd63", dout_b[0], 8'h00);
      addr_a = 6'd2; addr_b = 6'd10;
      @(negedge clk);
      chk8("busy_wr_ignored", dout_a[0], 8'h00);
      chk1("busy_wr_vld", vld_a[0], 1'b1);
      chk8("reclr_rd10", dout_b[0], 8'h00);
      en_a = 1'b0; en_b = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dual_port_ram_p.md
Name: dual_port_ram_p

Overview:
- Parametrised true dual-port synchronous RAM. Next generation of the team's 8x64 dual-port RAM.
- Adds configurable width and depth, per-port enables and read-valid strobes, and selectable same-port read-during-write mode.
- Adds deterministic write-collision arbitration with a flag, an optional output pipeline register, and a hardware clear sequencer.
- Used as the shared buffer between two independent requesters in the same clock domain.

Parameters:
- DATA_W, 8, data width per word.
- ADDR_W, 6, address width. Depth = 2**ADDR_W words.
- RDW_MODE, 0, same-port read-during-write behaviour: 0 = hold dout, no valid (legacy); 1 = write-first (new data); 2 = read-first (old data).
- OUT_REG, 0, 1 adds an output pipeline stage (read latency 2 instead of 1).
- CLR_ON_RST, 1, 1 runs the clear sequence automatically after reset release.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous request to zero the whole array; single-cycle pulse, sampled in IDLE only.
- busy  out  1  clear sequence in progress; port accesses are ignored.
- en_a  in  1  port A access enable.
- we_a  in  1  port A write enable; qualified by en_a.
- addr_a  in  ADDR_W  port A address.
- din_a  in  DATA_W  port A write data.
- dout_a  out  DATA_W  port A read data.
- vld_a  out  1  dout_a holds data for a completed read.
- en_b, we_b, addr_b, din_b, dout_b, vld_b: port B equivalents.
- collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle.

Behaviour:
- Reset (rst_n=0, async):
  - dout_a/b=0, vld_a/b=0, collision=0, clear counter=0.
  - FSM forced to IDLE; busy=0 while reset is asserted.
  - Array contents are not reset directly.
- FSM states: IDLE, CLEAR.
  - IDLE->CLEAR on the first clk edge after rst_n rises if CLR_ON_RST=1, or on clr=1 in IDLE.
  - In CLEAR: write 0 to address cnt each cycle; cnt increments 0..2**ADDR_W-1. Leave to IDLE on the cycle cnt=2**ADDR_W-1 is written.
  - busy=1 throughout CLEAR, exactly 2**ADDR_W cycles.
  - clr while busy is ignored.
  - rst_n low mid-clear aborts immediately; contents are partially cleared; the sequence restarts from 0 after release if CLR_ON_RST=1.
- While busy: en_a/en_b are ignored, no user writes occur, and vld_a/vld_b stay 0.
- Read (en=1, we=0):
  - OUT_REG=0: dout = mem[addr] at edge N+1, vld=1 for that one cycle.
  - OUT_REG=1: the same values appear one cycle later.
  - dout holds its last value when vld=0.
- Write (en=1, we=1): mem[addr] <= din at edge N. The same-port output depends on RDW_MODE:
  - Mode 0: dout unchanged, vld=0.
  - Mode 1: dout=din, vld=1.
  - Mode 2: dout=old mem[addr], vld=1.
- Cross-port read of an address being written by the other port in the same cycle always returns old data.
- Write-write collision (both ports enabled and writing, addr_a==addr_b):
  - Port A data is stored; port B write is dropped.
  - collision=1 for exactly the following cycle.
  - Different addresses never set collision.
- en=0: no access; vld=0 next cycle (at the pipeline output when OUT_REG=1).
- Addresses are always in range; no wrap logic is needed. The clear counter stops at the max address; it does not wrap during CLEAR.
- Ports A and B are fully independent apart from the collision rule above.

Test Plan:
- Reset release, CLR_ON_RST=1, ADDR_W=6 -> busy=1 for exactly 64 cycles; then reads of addresses 0, 31, 63 return 0x00 with vld=1 one cycle after the request.
- After clear: A writes 0x5A to addr 10; next cycle B reads addr 10 -> dout_b=0x5A, vld_b=1 at latency 1. With OUT_REG=1 the same result appears at latency 2.
- mem[7]=0x11; same cycle A writes 0x22 to addr 7 and B reads addr 7 -> dout_b=0x11. A subsequent B read -> 0x22.
- Same-port write 0x33 over 0x11 at addr 3, swept over RDW_MODE=0/1/2 -> dout_a unchanged with vld_a=0 / 0x33 with vld_a=1 / 0x11 with vld_a=1.
- A writes 0xAA and B writes 0xBB, both to addr 20, same cycle -> collision=1 for exactly one cycle; a read of addr 20 returns 0xAA. A repeat with addresses 20 and 21 gives collision=0.
- clr pulse, then rst_n low at clear cycle 30, then release -> busy=0 during reset; the clear restarts at addr 0 and busy=1 for 64 cycles. An access attempted while busy gives vld=0 and leaves memory unaffected.
